// File: rtl/mux_scan_reg.sv
// rtl/mux_scan_reg.sv - registered N-channel mux with manual select and auto-scan with dwell and pause
module mux_scan_reg #(
    parameter int WIDTH = 8,
    parameter int NCH   = 4,
    parameter int SELW  = 2,
    parameter int DWELL = 100000000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NCH*WIDTH-1:0] din,
    input  logic [SELW-1:0]      sel,
    input  logic                 mode,
    input  logic                 hold,
    output logic [WIDTH-1:0]     y,
    output logic [SELW-1:0]      y_sel,
    output logic                 chg
);

    // Counter only has to reach DWELL-1; keep at least one bit for DWELL=1.
    localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CW-1:0]   CNT_MAX  = CW'(DWELL - 1);
    localparam logic [SELW-1:0] LAST_CH  = SELW'(NCH - 1);
    localparam logic [SELW:0]   NCH_CODE = (SELW + 1)'(NCH);

    typedef enum logic [1:0] {
        MAN   = 2'd0,
        SCAN  = 2'd1,
        PAUSE = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_nxt;
    logic [SELW-1:0] nsel;
    logic [WIDTH-1:0] y_nxt;

    // Next state, next channel index, next dwell count and the data slice it selects.
    // Behaviour follows the state being entered, so mode/hold act on the same edge they are seen.
    always_comb begin
        state_nxt = state;
        nsel      = y_sel;
        cnt_nxt   = cnt;
        y_nxt     = '0;

        if (!mode) begin
            state_nxt = MAN;
        end else begin
            case (state)
                MAN:     state_nxt = hold ? PAUSE : SCAN;
                SCAN:    state_nxt = hold ? PAUSE : SCAN;
                PAUSE:   state_nxt = hold ? PAUSE : SCAN;
                default: state_nxt = MAN;
            endcase
        end

        case (state_nxt)
            MAN: begin
                cnt_nxt = '0;
                // Out-of-range codes keep the previous channel.
                if ({1'b0, sel} < NCH_CODE) begin
                    nsel = sel;
                end
            end
            SCAN: begin
                if (state == MAN) begin
                    // Scan starts from the channel already shown, with a fresh dwell.
                    cnt_nxt = '0;
                end else if (cnt == CNT_MAX) begin
                    cnt_nxt = '0;
                    nsel    = (y_sel == LAST_CH) ? '0 : y_sel + 1'b1;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            PAUSE: begin
                if (state == MAN) begin
                    cnt_nxt = '0;
                end
            end
            default: begin
                cnt_nxt = '0;
            end
        endcase

        // Only valid channel indices can match, so unused codes never reach y.
        for (int k = 0; k < NCH; k++) begin
            if (nsel == SELW'(k)) begin
                y_nxt = din[k*WIDTH +: WIDTH];
            end
        end
    end

    // Register state, counter and the coherent (y, y_sel, chg) output triple.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= MAN;
            cnt   <= '0;
            y_sel <= '0;
            y     <= '0;
            chg   <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            y_sel <= nsel;
            y     <= y_nxt;
            chg   <= (nsel != y_sel);
        end
    end

endmodule
